wb_arbiter_2m: RTL and testbench
================================

# wb_arbiter_2m

Two-master, one-slave Wishbone arbiter that shares the peripheral bus (frequency-counter and UART registers) between the measurement `control_unit` and a second master, such as a host command or debug engine. It applies round-robin fairness and honours `lock` for atomic sequences. A bus watchdog terminates any slave cycle that never responds, returning `err` to the owning master.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: stall cycles (strobe high, no ack/err/rty) before abort; legal range 1..65535.
- `TW`, default 16: width of the watchdog counter; must hold `TIMEOUT_CYCLES`.

Ports (N = 0, 1):
- `clk_i` in 1: single clock; all state updates on its rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `mN_cyc_i`, `mN_stb_i`, `mN_we_i`, `mN_lock_i` in 1 each: master N bus controls.
- `mN_addr_i` in 32, `mN_dat_i` in 32, `mN_sel_i` in 4: master N address, write data and byte selects.
- `mN_dat_o` out 32: read data to master N.
- `mN_ack_o`, `mN_err_o`, `mN_rty_o` out 1 each: terminations to master N.
- `s_cyc_o`, `s_stb_o`, `s_we_o`, `s_lock_o` out 1 each; `s_addr_o` out 32; `s_dat_o` out 32; `s_sel_o` out 4: slave side.
- `s_dat_i` in 32; `s_ack_i`, `s_err_i`, `s_rty_i` in 1 each: slave responses.
- `grant_o` out 2: one-hot current owner; 00 means none.
- `timeout_o` out 1: one-cycle pulse when the watchdog fires.

## Operation
- State machine: IDLE, BUSY, ABORT.
- **IDLE:** `grant_o`=00 and all `s_*` outputs are 0.
  - A request is `mN_cyc_i`=1.
  - With one requester, grant it.
  - With both requesting, grant the master not granted last (`last_grant` register).
  - Go to BUSY.
- **BUSY:** `s_*` outputs are a combinational mux of the granted master's inputs.
  - Responses route only to the owner: `mN_ack_o` = `s_ack_i` & `grant_o`[N]; same rule for `err` and `rty`.
  - `mN_dat_o` = `s_dat_i` for both masters; the non-owner sees no termination.
  - Release when the owner has `cyc_i`=0 and `lock_i`=0. Then go to IDLE, `grant_o` goes to 00, and `last_grant` is updated.
  - While the owner's `lock_i`=1, the grant is held even across `cyc_i`=0 gaps, and the other master waits.
- **Watchdog:** runs in BUSY only.
  - The counter increments each cycle with `s_stb_o`=1 and `s_ack_i`|`s_err_i`|`s_rty_i`=0.
  - It clears on any termination, and when `s_stb_o`=0.
  - When the count equals `TIMEOUT_CYCLES`, go to ABORT.
- **ABORT:** first cycle:
  - `s_cyc_o`, `s_stb_o` and `s_lock_o` are 0.
  - `err_o` of the owner is 1 for exactly this cycle.
  - `timeout_o`=1 for exactly this cycle.
  - Late slave responses in ABORT are ignored and not routed.
- **ABORT:** following cycles: stay until the owner drops `cyc_i` (ignoring `lock_i`), then go to IDLE with `last_grant` updated.
- Reset values: state IDLE, `grant_o`=00, `last_grant`=master 1 (so master 0 wins the first tie), counter 0, `timeout_o`=0, all `s_*` outputs 0, all `mN_ack`/`err`/`rty` 0.

## Timing
- Arbitration latency is 1 cycle: `cyc` sampled at edge k drives `grant_o` and `s_cyc_o` from edge k.
- A master's request made in IDLE appears on the slave bus in the cycle after it is first sampled.
- Ack path is combinational: slave ack in cycle c reaches the owner in cycle c. Single-cycle and pipelined-classic slaves need no extra wait.
- Release costs 1 IDLE cycle: the owner drops `cyc` at edge k, IDLE is entered at edge k+1, and the next grant takes effect at edge k+2. A requester gets the bus at most 2 cycles after the owner drops `cyc`, unless the owner is locked.
- Simultaneous requests from both masters in IDLE: exactly one is granted, by the round-robin rule; never both.
- Timeout fires on the cycle after `TIMEOUT_CYCLES` consecutive stall cycles. With the default, `err` occurs on stall cycle 256.
- Termination coinciding with the count reaching the limit: the termination wins. The response is routed, there is no ABORT, and the counter clears.
- `rst_i` mid-transfer: on the next edge all outputs return to reset values and the transfer is dropped with no termination issued.

## Test plan
- **Single master:** m0 writes 0x96feb5 to addr 0x4, slave acks in cycle 2 -> `grant_o`=01, `s_addr_o`=0x4, `s_dat_o`=0x96feb5, `s_sel_o`=1111, `m0_ack_o` pulses once, `m1_ack_o` stays 0.
- **Tie after reset:** both masters raise `cyc` in the same cycle -> m0 is granted first. After m0 releases, m1 is granted at most 2 cycles later. On the next tie, m0 is granted again (round-robin holds).
- **Lock:** m1 asserts `lock_i` with a `cyc` gap of 3 cycles between two transfers while m0 requests -> `grant_o` stays 10 throughout. m0 is granted only after m1 clears both `cyc` and `lock`.
- **Watchdog:** `TIMEOUT_CYCLES`=8, slave never responds to an m0 read of addr 0x9 -> after 8 stall cycles, `m0_err_o` and `timeout_o` each pulse 1 cycle and `s_cyc_o`=0. A late slave ack is not routed. The bus returns to IDLE when m0 drops `cyc`.
- **Boundary and reset:** ack arrives on the same cycle the counter reaches the limit -> ack delivered, no error. In a separate run, `rst_i` pulsed mid-BUSY -> next cycle `grant_o`=00, all `s_*` outputs 0, and the next tie goes to m0.

Source files
------------

// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave Wishbone arbiter with round-robin tie breaking, lock support
// and a bus watchdog that aborts stalled slave cycles with err to the owning master.
module wb_arbiter_2m #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TW             = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic        m0_lock_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_rty_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic        m1_lock_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_rty_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic        s_lock_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic        s_rty_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          last_grant_q, last_grant_d;  // index of the master that owned the bus last
  logic [TW-1:0] wdog_q, wdog_d;
  logic [TW-1:0] wdog_inc;
  logic          timeout_q, timeout_d;

  logic        own_cyc, own_stb, own_we, own_lock;
  logic [31:0] own_addr, own_dat;
  logic [3:0]  own_sel;
  logic        busy, stall, own_release;

  // Owner's request lines; grant_q is one-hot whenever they are used.
  always_comb begin
    if (grant_q[1]) begin
      own_cyc  = m1_cyc_i;
      own_stb  = m1_stb_i;
      own_we   = m1_we_i;
      own_lock = m1_lock_i;
      own_addr = m1_addr_i;
      own_dat  = m1_dat_i;
      own_sel  = m1_sel_i;
    end else begin
      own_cyc  = m0_cyc_i;
      own_stb  = m0_stb_i;
      own_we   = m0_we_i;
      own_lock = m0_lock_i;
      own_addr = m0_addr_i;
      own_dat  = m0_dat_i;
      own_sel  = m0_sel_i;
    end
  end

  assign busy        = (state_q == ST_BUSY);
  assign stall       = busy && own_stb && !(s_ack_i || s_err_i || s_rty_i);
  assign own_release = !own_cyc && !own_lock;
  assign wdog_inc    = wdog_q + TW'(1);

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    wdog_d       = wdog_q;
    timeout_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        wdog_d = '0;
        if (m0_cyc_i || m1_cyc_i) begin
          state_d = ST_BUSY;
          grant_d = (m0_cyc_i && (!m1_cyc_i || last_grant_q)) ? 2'b01 : 2'b10;
        end
      end
      ST_BUSY: begin
        if (own_release) begin
          state_d      = ST_IDLE;
          grant_d      = 2'b00;
          last_grant_d = grant_q[1];
          wdog_d       = '0;
        end else if (stall) begin
          if (wdog_inc == TW'(TIMEOUT_CYCLES)) begin
            state_d   = ST_ABORT;
            timeout_d = 1'b1;
            wdog_d    = '0;
          end else begin
            wdog_d = wdog_inc;
          end
        end else begin
          wdog_d = '0;
        end
      end
      ST_ABORT: begin
        wdog_d = '0;
        // Lock is deliberately ignored here: an aborted owner only has to drop cyc.
        if (!own_cyc) begin
          state_d      = ST_IDLE;
          grant_d      = 2'b00;
          last_grant_d = grant_q[1];
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
        wdog_d  = '0;
      end
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      grant_q      <= 2'b00;
      last_grant_q <= 1'b1;
      wdog_q       <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      wdog_q       <= wdog_d;
      timeout_q    <= timeout_d;
    end
  end

  // Slave side follows the owner only in BUSY; IDLE and ABORT keep the bus quiet.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_lock_o = 1'b0;
    s_addr_o = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    if (busy) begin
      s_cyc_o  = own_cyc;
      s_stb_o  = own_stb;
      s_we_o   = own_we;
      s_lock_o = own_lock;
      s_addr_o = own_addr;
      s_dat_o  = own_dat;
      s_sel_o  = own_sel;
    end
  end

  assign m0_ack_o  = busy && grant_q[0] && s_ack_i;
  assign m0_err_o  = (busy && grant_q[0] && s_err_i) || (timeout_q && grant_q[0]);
  assign m0_rty_o  = busy && grant_q[0] && s_rty_i;
  assign m1_ack_o  = busy && grant_q[1] && s_ack_i;
  assign m1_err_o  = (busy && grant_q[1] && s_err_i) || (timeout_q && grant_q[1]);
  assign m1_rty_o  = busy && grant_q[1] && s_rty_i;
  assign m0_dat_o  = s_dat_i;
  assign m1_dat_o  = s_dat_i;
  assign grant_o   = grant_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Self-checking bench for wb_arbiter_2m: directed scenarios plus randomized traffic,
// every cycle compared against an ownership-level reference model.
module tb_wb_arbiter_2m;

  localparam int TO = 8;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic        lock;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] dat;
  } mreq_t;

  logic clk_i = 1'b0;
  logic rst_i;
  mreq_t mst [2];

  logic        m0_cyc_i, m0_stb_i, m0_we_i, m0_lock_i;
  logic [31:0] m0_addr_i, m0_dat_i, m0_dat_o;
  logic [3:0]  m0_sel_i;
  logic        m0_ack_o, m0_err_o, m0_rty_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i, m1_lock_i;
  logic [31:0] m1_addr_i, m1_dat_i, m1_dat_o;
  logic [3:0]  m1_sel_i;
  logic        m1_ack_o, m1_err_o, m1_rty_o;
  logic        s_cyc_o, s_stb_o, s_we_o, s_lock_o;
  logic [31:0] s_addr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        s_ack_i, s_err_i, s_rty_i;
  logic [1:0]  grant_o;
  logic        timeout_o;

  assign m0_cyc_i  = mst[0].cyc;
  assign m0_stb_i  = mst[0].stb;
  assign m0_we_i   = mst[0].we;
  assign m0_lock_i = mst[0].lock;
  assign m0_addr_i = mst[0].addr;
  assign m0_dat_i  = mst[0].dat;
  assign m0_sel_i  = mst[0].sel;
  assign m1_cyc_i  = mst[1].cyc;
  assign m1_stb_i  = mst[1].stb;
  assign m1_we_i   = mst[1].we;
  assign m1_lock_i = mst[1].lock;
  assign m1_addr_i = mst[1].addr;
  assign m1_dat_i  = mst[1].dat;
  assign m1_sel_i  = mst[1].sel;

  wb_arbiter_2m #(.TIMEOUT_CYCLES(TO), .TW(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_lock_i(m0_lock_i),
    .m0_addr_i(m0_addr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_dat_o(m0_dat_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_lock_i(m1_lock_i),
    .m1_addr_i(m1_addr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_lock_o(s_lock_o),
    .s_addr_o(s_addr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: who owns the bus, whether that ownership is being aborted,
  // how many consecutive stall cycles have been seen, and who owned it last.
  int owner   = -1;
  int last    = 1;
  int stalls  = 0;
  bit aborting    = 1'b0;
  bit abort_first = 1'b0;
  bit cmp_en      = 1'b0;

  logic [1:0] obs_grant;
  mreq_t      obs_s;
  logic [2:0] obs_r [2];
  logic       obs_tmo;
  int         ack_cnt [2];
  int         err_cnt [2];
  int         tmo_cnt;

  task automatic compare_outputs();
    mreq_t      exp_s;
    logic [1:0] exp_g;
    logic [2:0] exp_r;
    bit         own, live;
    obs_grant = grant_o;
    obs_s     = {s_cyc_o, s_stb_o, s_we_o, s_lock_o, s_sel_o, s_addr_o, s_dat_o};
    obs_r[0]  = {m0_ack_o, m0_err_o, m0_rty_o};
    obs_r[1]  = {m1_ack_o, m1_err_o, m1_rty_o};
    obs_tmo   = timeout_o;
    for (int n = 0; n < 2; n++) begin
      if (obs_r[n][2] === 1'b1) ack_cnt[n]++;
      if (obs_r[n][1] === 1'b1) err_cnt[n]++;
    end
    if (obs_tmo === 1'b1) tmo_cnt++;

    exp_g = 2'b00;
    exp_s = '0;
    if (owner >= 0) begin
      exp_g = (owner == 0) ? 2'b01 : 2'b10;
      if (!aborting) exp_s = mst[owner];
    end
    check("grant", 128'(obs_grant), 128'(exp_g));
    check("s_bus", 128'(obs_s), 128'(exp_s));
    for (int n = 0; n < 2; n++) begin
      own   = (owner == n);
      live  = own && !aborting;
      exp_r = {live && s_ack_i, (live && s_err_i) || (own && abort_first), live && s_rty_i};
      check($sformatf("resp%0d", n), 128'(obs_r[n]), 128'(exp_r));
    end
    check("timeout", 128'(obs_tmo), 128'(abort_first));
    check("m0_dat", 128'(m0_dat_o), 128'(s_dat_i));
    check("m1_dat", 128'(m1_dat_o), 128'(s_dat_i));
  endtask

  task automatic model_update();
    bit term;
    term        = s_ack_i || s_err_i || s_rty_i;
    abort_first = 1'b0;
    if (rst_i) begin
      owner    = -1;
      last     = 1;
      stalls   = 0;
      aborting = 1'b0;
    end else if (owner < 0) begin
      if (mst[0].cyc && mst[1].cyc) owner = 1 - last;
      else if (mst[0].cyc)          owner = 0;
      else if (mst[1].cyc)          owner = 1;
      stalls = 0;
    end else if (aborting) begin
      if (!mst[owner].cyc) begin
        last     = owner;
        owner    = -1;
        aborting = 1'b0;
      end
    end else if (!mst[owner].cyc && !mst[owner].lock) begin
      last   = owner;
      owner  = -1;
      stalls = 0;
    end else if (mst[owner].stb && !term) begin
      stalls++;
      if (stalls == TO) begin
        aborting    = 1'b1;
        abort_first = 1'b1;
        stalls      = 0;
      end
    end else begin
      stalls = 0;
    end
  endtask

  // One bus cycle: compare on the falling edge, advance the model on the rising edge,
  // and return just after it so the caller can drive the next cycle's inputs.
  task automatic tick();
    @(negedge clk_i);
    if (cmp_en) compare_outputs();
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  task automatic set_m(input int n, input logic cyc, input logic stb, input logic we,
                       input logic lock, input logic [31:0] addr, input logic [31:0] dat);
    mst[n].cyc  = cyc;
    mst[n].stb  = stb;
    mst[n].we   = we;
    mst[n].lock = lock;
    mst[n].addr = addr;
    mst[n].dat  = dat;
    mst[n].sel  = 4'hf;
  endtask

  task automatic slave(input logic ack, input logic err, input logic rty);
    s_ack_i = ack;
    s_err_i = err;
    s_rty_i = rty;
  endtask

  task automatic clear_counts();
    ack_cnt = '{0, 0};
    err_cnt = '{0, 0};
    tmo_cnt = 0;
  endtask

  task automatic do_reset();
    set_m(0, 0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0, 0);
    slave(0, 0, 0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  int  n;
  int  r;
  bit  slave_dead;

  initial begin
    s_dat_i = 32'h1234_5678;
    clear_counts();
    do_reset();
    cmp_en = 1'b1;

    // Single master write, slave acks on the first bus cycle.
    set_m(0, 1, 1, 1, 0, 32'h4, 32'h0096_feb5);
    clear_counts();
    tick();
    check("t1_idle_grant", 128'(obs_grant), 128'(2'b00));
    slave(1, 0, 0);
    tick();
    check("t1_grant", 128'(obs_grant), 128'(2'b01));
    check("t1_addr", 128'(obs_s.addr), 128'(32'h4));
    check("t1_wdat", 128'(obs_s.dat), 128'(32'h0096_feb5));
    check("t1_sel", 128'(obs_s.sel), 128'(4'hf));
    set_m(0, 0, 0, 0, 0, 0, 0);
    slave(0, 0, 0);
    tick();
    tick();
    check("t1_m0_acks", 128'(ack_cnt[0]), 128'(1));
    check("t1_m1_acks", 128'(ack_cnt[1]), 128'(0));

    // Tie after reset, handover latency, round-robin on the next tie.
    do_reset();
    set_m(0, 1, 1, 0, 0, 32'h10, 0);
    set_m(1, 1, 1, 0, 0, 32'h20, 0);
    slave(1, 0, 0);
    tick();
    tick();
    check("t2_first_tie", 128'(obs_grant), 128'(2'b01));
    set_m(0, 0, 0, 0, 0, 0, 0);
    n = 0;
    do begin
      tick();
      n++;
    end while (obs_grant !== 2'b10 && n < 10);
    check("t2_handover_cycles", 128'(n), 128'(3));
    set_m(1, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    set_m(0, 1, 1, 0, 0, 32'h30, 0);
    set_m(1, 1, 1, 0, 0, 32'h40, 0);
    tick();
    tick();
    check("t2_second_tie", 128'(obs_grant), 128'(2'b01));
    set_m(0, 0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0, 0);
    tick();
    tick();

    // Locked sequence by m1 with a 3-cycle cyc gap while m0 waits.
    do_reset();
    set_m(1, 1, 1, 1, 1, 32'h50, 32'h5);
    slave(1, 0, 0);
    tick();
    tick();
    check("t3_lock_grant", 128'(obs_grant), 128'(2'b10));
    set_m(0, 1, 1, 0, 0, 32'h60, 0);
    set_m(1, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t3_gap%0d", i), 128'(obs_grant), 128'(2'b10));
    end
    set_m(1, 1, 1, 1, 1, 32'h54, 32'h6);
    tick();
    check("t3_second_xfer", 128'(obs_grant), 128'(2'b10));
    set_m(1, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    tick();
    check("t3_m0_after_unlock", 128'(obs_grant), 128'(2'b01));
    set_m(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();

    // Watchdog: slave never answers an m0 read of 0x9.
    do_reset();
    clear_counts();
    set_m(0, 1, 1, 0, 0, 32'h9, 0);
    slave(0, 0, 0);
    tick();
    n = 0;
    do begin
      tick();
      n++;
    end while (obs_tmo !== 1'b1 && n < 20);
    check("t4_timeout_cycle", 128'(n), 128'(TO + 1));
    check("t4_err_pulse", 128'(obs_r[0]), 128'(3'b010));
    check("t4_s_cyc_low", 128'(obs_s.cyc), 128'(1'b0));
    slave(1, 0, 0);
    tick();
    check("t4_late_ack", 128'(obs_r[0]), 128'(3'b000));
    check("t4_tmo_single", 128'(obs_tmo), 128'(1'b0));
    set_m(0, 0, 0, 0, 0, 0, 0);
    slave(0, 0, 0);
    tick();
    tick();
    check("t4_back_idle", 128'(obs_grant), 128'(2'b00));
    check("t4_err_count", 128'(err_cnt[0]), 128'(1));
    check("t4_tmo_count", 128'(tmo_cnt), 128'(1));

    // Ack on the very cycle the stall count would reach the limit.
    do_reset();
    clear_counts();
    set_m(0, 1, 1, 0, 0, 32'h70, 0);
    tick();
    for (int i = 0; i < TO - 1; i++) tick();
    slave(1, 0, 0);
    tick();
    check("t5_boundary_ack", 128'(obs_r[0]), 128'(3'b100));
    slave(0, 0, 0);
    tick();
    check("t5_no_timeout", 128'(obs_tmo), 128'(1'b0));
    set_m(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    check("t5_tmo_count", 128'(tmo_cnt), 128'(0));

    // Reset in the middle of an m1 transfer, after m0 owned the bus last.
    set_m(0, 1, 1, 0, 0, 32'h80, 0);
    slave(1, 0, 0);
    tick();
    tick();
    set_m(0, 0, 0, 0, 0, 0, 0);
    set_m(1, 1, 1, 1, 0, 32'h90, 32'h9);
    tick();
    tick();
    tick();
    check("t5_m1_owner", 128'(obs_grant), 128'(2'b10));
    set_m(0, 1, 1, 0, 0, 32'ha0, 0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tick();
    check("t5_rst_grant", 128'(obs_grant), 128'(2'b00));
    check("t5_rst_sbus", 128'(obs_s), 128'(0));
    check("t5_rst_resp1", 128'(obs_r[1]), 128'(3'b000));
    tick();
    check("t5_rst_tie", 128'(obs_grant), 128'(2'b01));

    // Randomized traffic against the model, with dead-slave phases to trip the watchdog.
    do_reset();
    slave_dead = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) slave_dead = ($urandom_range(0, 2) == 0);
      for (int m = 0; m < 2; m++) begin
        if ($urandom_range(0, 7) == 0)  mst[m].cyc  = ~mst[m].cyc;
        if ($urandom_range(0, 15) == 0) mst[m].lock = ~mst[m].lock;
        mst[m].stb  = mst[m].cyc && ($urandom_range(0, 9) != 0);
        mst[m].we   = 1'($urandom_range(0, 1));
        mst[m].addr = $urandom;
        mst[m].dat  = $urandom;
        mst[m].sel  = 4'($urandom_range(0, 15));
      end
      r = int'($urandom_range(0, 9));
      slave(!slave_dead && r < 4, !slave_dead && r == 4, !slave_dead && r == 5);
      s_dat_i = $urandom;
      rst_i   = ($urandom_range(0, 499) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
